// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider request arbiter.
package div_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 2;
    localparam int DEFAULT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Folds idx back into 0..n-1; callers never pass more than 2n-2.
    function automatic int wrap_index(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr.
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'(wrap_index(int'(rr_ptr) + k, NUM_REQ));
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_req_arbiter.sv
// Shares one handshaked divider between NUM_REQ requesters, one division at a time,
// with round-robin grants and divide-by-zero answered locally.
module div_req_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [WIDTH-1:0]              resp_quotient,
    output logic [WIDTH-1:0]              resp_remainder,
    output logic                          resp_div0,
    output logic                          div_src_valid,
    input  logic                          div_src_ready,
    output logic [WIDTH-1:0]              div_dividend,
    output logic [WIDTH-1:0]              div_divisor,
    input  logic                          div_dest_valid,
    output logic                          div_dest_ready,
    input  logic [WIDTH-1:0]              div_quotient,
    input  logic [WIDTH-1:0]              div_remainder
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Ready is gated by rst so no requester sees a handshake the reset will discard.
    assign req_ready      = (state == IDLE && !rst) ? arb_grant : '0;
    assign div_dest_ready = (state == WAIT) && div_dest_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            resp_valid     <= '0;
            resp_quotient  <= '0;
            resp_remainder <= '0;
            resp_div0      <= 1'b0;
            div_src_valid  <= 1'b0;
            div_dividend   <= '0;
            div_divisor    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant        <= arb_idx;
                        div_dividend <= req_dividend[arb_idx];
                        div_divisor  <= req_divisor[arb_idx];
                        if (req_divisor[arb_idx] == '0) begin
                            resp_quotient  <= '1;
                            resp_remainder <= req_dividend[arb_idx];
                            resp_div0      <= 1'b1;
                            resp_valid     <= arb_grant;
                            state          <= RESP;
                        end else begin
                            div_src_valid <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (div_src_ready) begin
                        div_src_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_dest_valid) begin
                        resp_quotient     <= div_quotient;
                        resp_remainder    <= div_remainder;
                        resp_div0         <= 1'b0;
                        resp_valid[grant] <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[grant]) begin
                        resp_valid <= '0;
                        rr_ptr     <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_arbiter.sv
// Randomised bench for div_req_arbiter: divider model, requester driver and a
// transaction-level round-robin/arithmetic reference model.
`timescale 1ns/1ps
module tb_div_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 16;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             d0;
    } resp_t;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_dividend;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_divisor;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ-1:0]            resp_ready;
    logic [WIDTH-1:0]              resp_quotient;
    logic [WIDTH-1:0]              resp_remainder;
    logic                          resp_div0;
    logic                          div_src_valid;
    logic                          div_src_ready;
    logic [WIDTH-1:0]              div_dividend;
    logic [WIDTH-1:0]              div_divisor;
    logic                          div_dest_valid;
    logic                          div_dest_ready;
    logic [WIDTH-1:0]              div_quotient;
    logic [WIDTH-1:0]              div_remainder;

    always #5 clk = ~clk;

    div_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_div0      (resp_div0),
        .div_src_valid  (div_src_valid),
        .div_src_ready  (div_src_ready),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_dest_valid (div_dest_valid),
        .div_dest_ready (div_dest_ready),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder)
    );

    int n_errors = 0;
    int n_checks = 0;

    op_t                opq [NUM_REQ][$];
    logic [NUM_REQ-1:0] acc_last = '0;
    int  resp_block = 0;
    int  src_block  = 0;
    int  div_lat    = -1;
    bit  rand_mode  = 1'b0;
    int  n_pushed   = 0;
    int  n_resp     = 0;
    int  src_valid_cycles = 0;
    int  src_hs_cnt = 0;
    int  grant_log[$];
    resp_t resp_log[$];
    int  last_latency = 0;
    int  last_src_stall = 0;
    int  last_resp_stall = 0;

    // Reference model: one outstanding transaction, pointer advanced past the served requester.
    bit               m_busy = 1'b0;
    bit               m_issued;
    bit               m_got;
    bit               m_seen;
    int               m_ptr = 0;
    int               m_idx, m_age, m_src_stall, m_resp_stall;
    resp_t            m_exp;
    logic [WIDTH-1:0] m_a, m_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic resp_t ref_div(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        resp_t r;
        r.idx = idx;
        if (b == 0) begin
            r.q  = '1;
            r.r  = a;
            r.d0 = 1'b1;
        end else begin
            r.q  = a / b;
            r.r  = a % b;
            r.d0 = 1'b0;
        end
        return r;
    endfunction

    task automatic push(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        opq[i].push_back(o);
        n_pushed++;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (n_resp < n_pushed && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 64'(n_resp >= n_pushed), 64'd1);
    endtask

    task automatic reset_dut(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        n_pushed = n_resp;
        grant_log.delete();
        resp_log.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_src_valid"}, 64'(div_src_valid), 64'd0);
        check({tag, "_dest_ready"}, 64'(div_dest_ready), 64'd0);
        check({tag, "_quotient"}, 64'(resp_quotient), 64'd0);
        check({tag, "_remainder"}, 64'(resp_remainder), 64'd0);
        check({tag, "_div0"}, 64'(resp_div0), 64'd0);
        check({tag, "_dividend"}, 64'(div_dividend), 64'd0);
        check({tag, "_divisor"}, 64'(div_divisor), 64'd0);
    endtask

    // Requester driver: holds the head of each queue valid until it is accepted.
    initial begin : driver
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_last[i] && opq[i].size() > 0) opq[i].delete(0);
                req_valid[i] = (opq[i].size() > 0);
                if (req_valid[i]) begin
                    req_dividend[i] = opq[i][0].a;
                    req_divisor[i]  = opq[i][0].b;
                end else if (rand_mode) begin
                    req_dividend[i] = WIDTH'($urandom);
                    req_divisor[i]  = WIDTH'($urandom);
                end
            end
            if (resp_block > 0) resp_ready = '0;
            else if (rand_mode) resp_ready = NUM_REQ'($urandom);
            else resp_ready = '1;
        end
    end

    // Divider model with variable latency and operand backpressure.
    initial begin : divider_model
        bit               busy, shs, dhs, was_rst;
        int               cnt;
        logic [WIDTH-1:0] a, b, q, r;
        busy = 1'b0;
        cnt  = 0;
        q    = '0;
        r    = '0;
        div_src_ready  = 1'b0;
        div_dest_valid = 1'b0;
        div_quotient   = '0;
        div_remainder  = '0;
        forever begin
            @(negedge clk);
            was_rst = rst;
            shs = div_src_valid && div_src_ready;
            dhs = div_dest_valid && div_dest_ready;
            a = div_dividend;
            b = div_divisor;
            if (div_src_valid && !div_src_ready && src_block > 0) src_block--;
            @(posedge clk); #1;
            if (was_rst) begin
                busy = 1'b0;
                div_dest_valid = 1'b0;
            end else begin
                if (dhs) begin
                    busy = 1'b0;
                    div_dest_valid = 1'b0;
                end
                if (shs) begin
                    busy = 1'b1;
                    q = (b == 0) ? '1 : a / b;
                    r = (b == 0) ? a : a % b;
                    cnt = (div_lat >= 0) ? div_lat : int'($urandom_range(0, 3));
                end
                if (busy && !div_dest_valid) begin
                    if (cnt == 0) begin
                        div_dest_valid = 1'b1;
                        div_quotient   = q;
                        div_remainder  = r;
                    end else begin
                        cnt--;
                    end
                end
            end
            div_src_ready = !busy && (src_block == 0) && (!rand_mode || $urandom_range(0, 2) != 0);
        end
    end

    // Monitor: samples on the falling edge and predicts what the next rising edge commits.
    initial begin : monitor
        int g;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("ready_in_rst", 64'(req_ready), 64'd0);
                acc_last = '0;
                m_busy   = 1'b0;
                m_ptr    = 0;
            end else begin
                acc_last = req_valid & req_ready;
                if (div_src_valid) src_valid_cycles++;
                if (div_src_valid && div_src_ready) src_hs_cnt++;
                check("dest_ready_no_valid", 64'(div_dest_ready && !div_dest_valid), 64'd0);
                if (!m_busy) begin
                    g = -1;
                    for (int k = 0; k < NUM_REQ; k++)
                        if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                    check("resp_when_idle", 64'(resp_valid), 64'd0);
                    check("src_when_idle", 64'(div_src_valid), 64'd0);
                    if (g < 0) begin
                        check("ready_none", 64'(req_ready), 64'd0);
                    end else begin
                        check("grant", 64'(req_ready), 64'd1 << g);
                        m_busy = 1'b1;
                        m_idx  = g;
                        m_a    = req_dividend[g];
                        m_b    = req_divisor[g];
                        m_exp  = ref_div(g, m_a, m_b);
                        m_age  = 0;
                        m_issued = 1'b0;
                        m_got  = 1'b0;
                        m_seen = 1'b0;
                        m_src_stall  = 0;
                        m_resp_stall = 0;
                        grant_log.push_back(g);
                    end
                end else begin
                    m_age++;
                    check("ready_busy", 64'(req_ready), 64'd0);
                    if (div_src_valid) begin
                        check("src_on_div0", 64'(m_exp.d0), 64'd0);
                        check("op_dividend", 64'(div_dividend), 64'(m_a));
                        check("op_divisor", 64'(div_divisor), 64'(m_b));
                        if (div_src_ready) m_issued = 1'b1;
                        else m_src_stall++;
                    end else if (m_issued && !m_got && div_dest_valid) begin
                        check("dest_ready", 64'(div_dest_ready), 64'd1);
                        m_got = 1'b1;
                    end
                    if (resp_valid != 0) begin
                        if (!m_seen) begin
                            m_seen = 1'b1;
                            last_latency = m_age;
                        end
                        check("resp_onehot", 64'(resp_valid), 64'd1 << m_idx);
                        check("resp_quotient", 64'(resp_quotient), 64'(m_exp.q));
                        check("resp_remainder", 64'(resp_remainder), 64'(m_exp.r));
                        check("resp_div0", 64'(resp_div0), 64'(m_exp.d0));
                        if (resp_block > 0) resp_block--;
                        if (resp_ready[m_idx]) begin
                            resp_log.push_back('{m_idx, resp_quotient, resp_remainder, resp_div0});
                            last_src_stall  = m_src_stall;
                            last_resp_stall = m_resp_stall;
                            m_ptr  = (m_idx + 1) % NUM_REQ;
                            m_busy = 1'b0;
                            n_resp++;
                        end else begin
                            m_resp_stall++;
                        end
                    end else if (m_age > 200) begin
                        check("txn_timeout", 64'(m_age), 64'd0);
                        m_busy = 1'b0;
                        n_resp++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst = 1'b1;
        reset_dut(2);
        @(negedge clk);
        check_all_zero("reset");

        // Single request.
        push(0, 16'd100, 16'd7);
        wait_done(200);
        check("single_count", 64'(resp_log.size()), 64'd1);
        if (resp_log.size() >= 1) begin
            check("single_idx", 64'(resp_log[0].idx), 64'd0);
            check("single_q", 64'(resp_log[0].q), 64'd14);
            check("single_r", 64'(resp_log[0].r), 64'd2);
            check("single_d0", 64'(resp_log[0].d0), 64'd0);
        end

        // Simultaneous requests after reset: requester 0 wins first.
        reset_dut(1);
        push(0, 16'd40, 16'd6);
        push(1, 16'd9, 16'd4);
        wait_done(200);
        check("simul_count", 64'(resp_log.size()), 64'd2);
        if (resp_log.size() >= 2) begin
            check("simul_first_idx", 64'(resp_log[0].idx), 64'd0);
            check("simul_first_q", 64'(resp_log[0].q), 64'd6);
            check("simul_first_r", 64'(resp_log[0].r), 64'd4);
            check("simul_second_idx", 64'(resp_log[1].idx), 64'd1);
            check("simul_second_q", 64'(resp_log[1].q), 64'd2);
            check("simul_second_r", 64'(resp_log[1].r), 64'd1);
        end

        // Fairness: both requesters continuously valid.
        grant_log.delete();
        resp_log.delete();
        for (int k = 0; k < 3; k++) begin
            push(0, WIDTH'($urandom), WIDTH'($urandom_range(1, 300)));
            push(1, WIDTH'($urandom), WIDTH'($urandom_range(1, 300)));
        end
        wait_done(400);
        check("fair_count", 64'(grant_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++)
            check($sformatf("fair_grant%0d", k), 64'(grant_log[k]), 64'(k % 2));

        // Divide by zero is answered without the divider.
        resp_log.delete();
        src_valid_cycles = 0;
        push(1, 16'd1234, 16'd0);
        wait_done(200);
        check("div0_count", 64'(resp_log.size()), 64'd1);
        if (resp_log.size() >= 1) begin
            check("div0_idx", 64'(resp_log[0].idx), 64'd1);
            check("div0_q", 64'(resp_log[0].q), 64'hFFFF);
            check("div0_r", 64'(resp_log[0].r), 64'd1234);
            check("div0_flag", 64'(resp_log[0].d0), 64'd1);
        end
        check("div0_latency", 64'(last_latency), 64'd1);
        check("div0_src_unused", 64'(src_valid_cycles), 64'd0);

        // Backpressure on both the divider input and the response.
        resp_log.delete();
        src_block  = 3;
        resp_block = 5;
        push(0, 16'd50000, 16'd123);
        wait_done(300);
        check("bp_src_stall", 64'(last_src_stall), 64'd3);
        check("bp_resp_stall", 64'(last_resp_stall), 64'd5);
        if (resp_log.size() >= 1) begin
            check("bp_q", 64'(resp_log[0].q), 64'd406);
            check("bp_r", 64'(resp_log[0].r), 64'd62);
        end

        // Reset while waiting on a slow divider abandons the transaction.
        resp_log.delete();
        div_lat = 20;
        begin
            int start_hs = src_hs_cnt;
            int t = 0;
            push(0, 16'd1000, 16'd3);
            while (src_hs_cnt == start_hs && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            check("rst_issue_seen", 64'(src_hs_cnt != start_hs), 64'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        div_lat = -1;
        n_pushed = n_resp;
        @(negedge clk);
        check_all_zero("midwait_rst");
        check("midwait_no_resp", 64'(resp_log.size()), 64'd0);
        push(0, 16'd65234, 16'd32770);
        push(1, 16'd7, 16'd7);
        wait_done(300);
        check("post_rst_count", 64'(resp_log.size()), 64'd2);
        if (resp_log.size() >= 1) begin
            check("post_rst_idx", 64'(resp_log[0].idx), 64'd0);
            check("post_rst_q", 64'(resp_log[0].q), 64'd1);
            check("post_rst_r", 64'(resp_log[0].r), 64'd32464);
        end

        // Randomised traffic with random backpressure on every handshake.
        rand_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                int i = int'($urandom_range(0, NUM_REQ - 1));
                logic [WIDTH-1:0] a = WIDTH'($urandom);
                logic [WIDTH-1:0] b;
                case ($urandom_range(0, 5))
                    0: b = '0;
                    1: b = 16'd1;
                    2: begin b = WIDTH'($urandom_range(1000, 65535)); a = WIDTH'($urandom_range(0, 999)); end
                    3: begin a = '1; b = WIDTH'($urandom_range(1, 65535)); end
                    4: b = WIDTH'($urandom_range(1, 255));
                    default: b = WIDTH'($urandom);
                endcase
                push(i, a, b);
            end
        end
        wait_done(20000);
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/div_req_arbiter.md
DIV_REQ_ARBITER -- requirements
Module: div_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, 2, number of requesters sharing one divider (2..8).
REQ-002 SHALL have parameter WIDTH, 16, operand and result width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid / req_ready  input / output  NUM_REQ  per-requester request handshake.
REQ-006 SHALL have port req_dividend / req_divisor  input  NUM_REQ x WIDTH  per-requester unsigned operands.
REQ-007 SHALL have port resp_valid / resp_ready  output / input  NUM_REQ  per-requester response handshake; resp_valid is one-hot or zero.
REQ-008 SHALL have port resp_quotient / resp_remainder / resp_div0  output  WIDTH / WIDTH / 1  shared response bus, meaningful only while some resp_valid bit is high.
REQ-009 SHALL have port div_src_valid / div_src_ready  output / input  1  divider operand handshake.
REQ-010 SHALL have port div_dividend / div_divisor  output  WIDTH  operands to the divider.
REQ-011 SHALL have port div_dest_valid / div_dest_ready  input / output  1  divider result handshake.
REQ-012 SHALL have port div_quotient / div_remainder  input  WIDTH  divider results.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE with any req_valid high, SHALL grant the first requester at or after rr_ptr (wrapping modulo NUM_REQ) whose valid is high.
REQ-015 In IDLE, SHALL assert req_ready combinationally only for the granted index; the grant, dividend and divisor SHALL be latched on that edge.
REQ-016 In IDLE with all req_valid low, SHALL stay in IDLE with all req_ready low.
REQ-017 A latched divisor of 0 SHALL go IDLE->RESP with quotient all-ones, remainder equal to the dividend and resp_div0=1. The divider SHALL not be used.
REQ-018 A nonzero latched divisor SHALL go IDLE->ISSUE.
REQ-019 In ISSUE, div_src_valid SHALL be 1 and the latched operands SHALL be held stable; the FSM SHALL go to WAIT on the edge where div_src_ready=1.
REQ-020 In WAIT, SHALL capture div_quotient/div_remainder on the first edge with div_dest_valid=1, assert div_dest_ready for exactly that cycle, and go to RESP with resp_div0=0.
REQ-021 In RESP, resp_valid[grant] SHALL be 1 and the response bus SHALL be held stable until resp_ready[grant]=1. resp_ready of other indices SHALL be ignored.
REQ-022 On RESP completion, SHALL set rr_ptr = grant+1 (wrapping to 0 after NUM_REQ-1) and return to IDLE; no new grant is made in that cycle.
REQ-023 Only one division SHALL be outstanding at a time.
REQ-024 Minimum request-to-response latency SHALL be 1 cycle for divide-by-zero and divider latency + 2 cycles otherwise.
REQ-025 Arithmetic SHALL be unsigned and WIDTH bits wide; no sign handling.

Reset
REQ-026 rst SHALL force, on the next edge: FSM to IDLE, rr_ptr=0, all req_ready/resp_valid=0, div_src_valid=0, div_dest_ready=0, response bus=0.
REQ-027 Reset asserted in any state mid-operation SHALL abandon the transaction without a response. The divider shares rst and is reset with it.

Structure
REQ-028 Package div_arb_pkg SHALL hold the FSM state enum typedef and the default WIDTH/NUM_REQ constants.
REQ-029 Sub-module rr_arbiter SHALL compute the one-hot grant from req_valid and rr_ptr. It SHALL be purely combinational and instantiated once.

Verification
REQ-030 Single request: req0 100/7 -> resp_valid[0] with quotient 14, remainder 2, resp_div0=0.
REQ-031 Simultaneous: req0 40/6 and req1 9/4 held valid after reset -> req0 served first (6, 4), then req1 (2, 1).
REQ-032 Fairness: req0 and req1 both continuously valid for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-033 Divide by zero: req1 1234/0 -> resp_valid[1] with quotient 16'hFFFF, remainder 1234, resp_div0=1, one cycle after acceptance; div_src_valid never asserted.
REQ-034 Backpressure: hold resp_ready low for 5 cycles and hold div_src_ready low for 3 cycles -> operands and response bus stable throughout, then a correct single response.
REQ-035 Reset mid-WAIT: assert rst for 1 cycle -> all outputs 0 next cycle; a following request 65234/32770 -> quotient 1, remainder 32464.
